// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point FFT front end.
package fft8_pkg;

    localparam int N_POINTS = 8;
    localparam int CNT_W    = 3;
    localparam int FP32_W   = 32;

    localparam logic [FP32_W-1:0] FP32_ONE = 32'h3F80_0000;

    typedef enum logic [1:0] {
        S_FILL,
        S_START,
        S_BUSY
    } loader_state_t;

    typedef struct packed {
        logic [FP32_W-1:0] re;
        logic [FP32_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft8_input_loader_if.sv
// Sample stream into the FFT8 loader: valid/ready handshake carrying one complex word.
interface fft8_input_loader_if #(
    parameter int SIZE_DATA = 32
);
    logic                 i_valid;
    logic                 o_ready;
    logic [SIZE_DATA-1:0] i_real;
    logic [SIZE_DATA-1:0] i_imag;
    logic                 i_last;

    modport master (
        output i_valid,
        output i_real,
        output i_imag,
        output i_last,
        input  o_ready
    );

    modport slave (
        input  i_valid,
        input  i_real,
        input  i_imag,
        input  i_last,
        output o_ready
    );
endinterface

// File: rtl/fft8_input_loader.sv
// Serial-to-parallel loader for the FFT8 core: 8 accepts fill the frame, then start/hold until done.
// Optional i_last framing check enabled by defining FFT8_LOADER_FRAME_CHECK_EN.
module fft8_input_loader
    import fft8_pkg::*;
#(
    parameter int SIZE_DATA = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    fft8_input_loader_if.slave   s_in,
    output logic [SIZE_DATA-1:0] x0_real,
    output logic [SIZE_DATA-1:0] x1_real,
    output logic [SIZE_DATA-1:0] x2_real,
    output logic [SIZE_DATA-1:0] x3_real,
    output logic [SIZE_DATA-1:0] x4_real,
    output logic [SIZE_DATA-1:0] x5_real,
    output logic [SIZE_DATA-1:0] x6_real,
    output logic [SIZE_DATA-1:0] x7_real,
    output logic [SIZE_DATA-1:0] x0_imag,
    output logic [SIZE_DATA-1:0] x1_imag,
    output logic [SIZE_DATA-1:0] x2_imag,
    output logic [SIZE_DATA-1:0] x3_imag,
    output logic [SIZE_DATA-1:0] x4_imag,
    output logic [SIZE_DATA-1:0] x5_imag,
    output logic [SIZE_DATA-1:0] x6_imag,
    output logic [SIZE_DATA-1:0] x7_imag,
    output logic                 o_start,
    input  logic                 i_fft_done,
    output logic                 o_busy,
    output logic                 o_err
);

    loader_state_t    state;
    logic [CNT_W-1:0] cnt;
    cplx_t            slot [N_POINTS];
    logic             start_q;
    logic             busy_q;
    logic             err_q;
    logic             accept;
    logic             last_slot;
    logic             frame_err;

    assign s_in.o_ready = (state == S_FILL);
    assign accept       = s_in.i_valid && s_in.o_ready;
    assign last_slot    = (cnt == CNT_W'(N_POINTS - 1));

`ifdef FFT8_LOADER_FRAME_CHECK_EN
    // i_last must coincide exactly with the 8th slot; either mismatch aborts the frame.
    assign frame_err = s_in.i_last ^ last_slot;
`else
    logic unused_last;
    assign unused_last = s_in.i_last;
    assign frame_err   = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_FILL;
            cnt     <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_POINTS; i++) begin
                slot[i] <= '0;
            end
        end else begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        slot[cnt] <= '{re: s_in.i_real, im: s_in.i_imag};
                        if (frame_err) begin
                            cnt   <= '0;
                            err_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            if (last_slot) begin
                                state   <= S_START;
                                start_q <= 1'b1;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                end
                S_START: begin
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (i_fft_done) begin
                        state  <= S_FILL;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_FILL;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_start = start_q;
    assign o_busy  = busy_q;
    assign o_err   = err_q;

    assign x0_real = slot[0].re;
    assign x1_real = slot[1].re;
    assign x2_real = slot[2].re;
    assign x3_real = slot[3].re;
    assign x4_real = slot[4].re;
    assign x5_real = slot[5].re;
    assign x6_real = slot[6].re;
    assign x7_real = slot[7].re;
    assign x0_imag = slot[0].im;
    assign x1_imag = slot[1].im;
    assign x2_imag = slot[2].im;
    assign x3_imag = slot[3].im;
    assign x4_imag = slot[4].im;
    assign x5_imag = slot[5].im;
    assign x6_imag = slot[6].im;
    assign x7_imag = slot[7].im;

endmodule

// File: tb/tb_fft8_input_loader.sv
// Scoreboard bench for fft8_input_loader: frames expected by a slot model are queued and popped on o_start.
module tb_fft8_input_loader;
    import fft8_pkg::*;

`ifdef FFT8_LOADER_FRAME_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_fft_done;
    logic        o_start, o_busy, o_err;
    logic [31:0] x_re [8];
    logic [31:0] x_im [8];

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int err_cnt = 0;

    logic [511:0] m_frame;
    int           m_cnt;
    int           m_err_exp;
    logic [511:0] sb_q [$];

    fft8_input_loader_if #(.SIZE_DATA(32)) bus ();

    fft8_input_loader #(.SIZE_DATA(32)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .s_in(bus.slave),
        .x0_real(x_re[0]), .x1_real(x_re[1]), .x2_real(x_re[2]), .x3_real(x_re[3]),
        .x4_real(x_re[4]), .x5_real(x_re[5]), .x6_real(x_re[6]), .x7_real(x_re[7]),
        .x0_imag(x_im[0]), .x1_imag(x_im[1]), .x2_imag(x_im[2]), .x3_imag(x_im[3]),
        .x4_imag(x_im[4]), .x5_imag(x_im[5]), .x6_imag(x_im[6]), .x7_imag(x_im[7]),
        .o_start(o_start), .i_fft_done(i_fft_done), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_start === 1'b1) start_cnt++;
        if (o_err === 1'b1) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [511:0] dut_frame();
        logic [511:0] f;
        for (int i = 0; i < 8; i++) f[i*64 +: 64] = {x_re[i], x_im[i]};
        return f;
    endfunction

    task automatic model_reset();
        m_frame = '0;
        m_cnt   = 0;
    endtask

    task automatic model_accept(input logic [31:0] re, input logic [31:0] im, input bit last);
        m_frame[m_cnt*64 +: 64] = {re, im};
        if (CHECK_EN && (last != (m_cnt == 7))) begin
            m_cnt = 0;
            m_err_exp++;
        end else if (m_cnt == 7) begin
            sb_q.push_back(m_frame);
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic send(input logic [31:0] re, input logic [31:0] im, input bit last, input int gap);
        int waited = 0;
        bus.i_valid = 1'b1;
        bus.i_real  = re;
        bus.i_imag  = im;
        bus.i_last  = last;
        while (bus.o_ready !== 1'b1 && waited < 64) begin
            tick();
            waited++;
        end
        checks++;
        if (bus.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready_timeout ready=%b expected=1", bus.o_ready);
            bus.i_valid = 1'b0;
            return;
        end
        tick();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        model_accept(re, im, last);
        repeat (gap) tick();
    endtask

    task automatic send_next(input logic [31:0] re, input logic [31:0] im, input int gap);
        send(re, im, (m_cnt == 7), gap);
    endtask

    task automatic expect_frame(input string name);
        logic [511:0] exp_f;
        checks++;
        if (o_start !== 1'b1) begin
            failures++;
            $display("FAIL %s_start_pulse o_start=%b expected=1", name, o_start);
        end
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard_empty got=0 frames expected>=1", name);
        end else begin
            exp_f = sb_q.pop_front();
            if (dut_frame() !== exp_f) begin
                failures++;
                $display("FAIL %s_frame got=%h expected=%h", name, dut_frame(), exp_f);
            end
        end
        tick();
        checks++;
        if (o_start !== 1'b0 || o_busy !== 1'b1 || bus.o_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_post_start start/busy/ready=%b%b%b expected=010",
                     name, o_start, o_busy, bus.o_ready);
        end
    endtask

    task automatic release_done(input string name);
        i_fft_done = 1'b1;
        tick();
        i_fft_done = 1'b0;
        checks++;
        if (bus.o_ready !== 1'b1 || o_busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_release ready/busy=%b%b expected=10", name, bus.o_ready, o_busy);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_fft_done = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_real = '0;
        bus.i_imag = '0;
        bus.i_last = 1'b0;
        model_reset();
        m_err_exp = 0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        checks++;
        if (o_start !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0 || bus.o_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl start/busy/err/ready=%b%b%b%b expected=0001",
                     o_start, o_busy, o_err, bus.o_ready);
        end
        checks++;
        if (dut_frame() !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h expected=0", dut_frame());
        end
    endtask

    task automatic test_dc_frame();
        int s0 = start_cnt;
        int bad = 0;
        for (int i = 0; i < 8; i++) send_next(FP32_ONE, 32'h0, 0);
        expect_frame("dc");
        for (int i = 0; i < 6; i++) begin
            if (bus.o_ready !== 1'b0 || o_start !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL dc_hold bad_cycles=%0d expected=0", bad);
        end
        release_done("dc");
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL dc_start_count got=%0d expected=1", start_cnt - s0);
        end
    endtask

    task automatic test_impulse_gaps();
        int s0 = start_cnt;
        send_next(FP32_ONE, 32'h0, 2);
        for (int i = 1; i < 8; i++) send_next(32'h0, 32'h0, (i == 7) ? 0 : 2);
        expect_frame("impulse");
        release_done("impulse");
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL impulse_start_count got=%0d expected=1", start_cnt - s0);
        end
    endtask

    task automatic test_stall();
        logic [511:0] held;
        int bad = 0;
        for (int i = 0; i < 8; i++) send_next(32'h4100_0000 + i, 32'hC000_0000 + i, 0);
        expect_frame("stall");
        held = dut_frame();
        bus.i_valid = 1'b1;
        bus.i_real = 32'hDEAD_BEEF;
        bus.i_imag = 32'hCAFE_F00D;
        for (int i = 0; i < 20; i++) begin
            if (bus.o_ready !== 1'b0) bad++;
            tick();
        end
        bus.i_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_ready bad_cycles=%0d expected=0", bad);
        end
        checks++;
        if (dut_frame() !== held) begin
            failures++;
            $display("FAIL stall_hold got=%h expected=%h", dut_frame(), held);
        end
        release_done("stall");
        send_next(32'h4000_0000, 32'h4040_0000, 0);
        checks++;
        if (x_re[0] !== 32'h4000_0000 || x_im[0] !== 32'h4040_0000) begin
            failures++;
            $display("FAIL stall_resume_x0 got=%h/%h expected=40000000/40400000", x_re[0], x_im[0]);
        end
        for (int i = 1; i < 8; i++) send_next(32'h3F00_0000 + i, 32'h0, 0);
        expect_frame("stall2");
        release_done("stall2");
    endtask

    task automatic test_spurious_done();
        int s0 = start_cnt;
        for (int i = 0; i < 4; i++) send_next(32'h4200_0000 + i, 32'h1, 1);
        i_fft_done = 1'b1;
        tick();
        i_fft_done = 1'b0;
        checks++;
        if (bus.o_ready !== 1'b1 || o_busy !== 1'b0 || o_start !== 1'b0) begin
            failures++;
            $display("FAIL spurious_done ready/busy/start=%b%b%b expected=100",
                     bus.o_ready, o_busy, o_start);
        end
        for (int i = 4; i < 8; i++) send_next(32'h4200_0000 + i, 32'h1, 0);
        expect_frame("spurious");
        release_done("spurious");
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL spurious_start_count got=%0d expected=1", start_cnt - s0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int s0 = start_cnt;
        for (int i = 0; i < 3; i++) send_next(32'h4300_0000 + i, 32'h7, 0);
        #2 i_rst = 1'b1;
        #1;
        checks++;
        if (dut_frame() !== '0 || o_start !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs frame=%h start/busy/err=%b%b%b expected=0 000",
                     dut_frame(), o_start, o_busy, o_err);
        end
        model_reset();
        repeat (2) tick();
        i_rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (start_cnt != s0) begin
            failures++;
            $display("FAIL midrst_no_start got=%0d expected=0", start_cnt - s0);
        end
        for (int i = 0; i < 8; i++) send_next(32'h4400_0000 + i, 32'h8000_0000 + i, 0);
        expect_frame("midrst");
        release_done("midrst");
    endtask

    task automatic test_frame_check();
        int s0 = start_cnt;
        for (int i = 0; i < 4; i++) send_next(32'h4500_0000 + i, 32'h2, 0);
        send(32'h4500_0004, 32'h2, 1'b1, 0);
        checks++;
        if (o_err !== CHECK_EN) begin
            failures++;
            $display("FAIL framechk_err o_err=%b expected=%b", o_err, CHECK_EN);
        end
        tick();
        checks++;
        if (o_err !== 1'b0 || o_start !== 1'b0) begin
            failures++;
            $display("FAIL framechk_after err/start=%b%b expected=00", o_err, o_start);
        end
        send_next(32'h4600_0000, 32'h4600_0001, 0);
        checks++;
        if (dut_frame() !== m_frame) begin
            failures++;
            $display("FAIL framechk_next_slot got=%h expected=%h", dut_frame(), m_frame);
        end
        while (m_cnt != 0) send_next(32'h4700_0000 + m_cnt, 32'h3, 0);
        expect_frame("framechk");
        release_done("framechk");
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL framechk_start_count got=%0d expected=1", start_cnt - s0);
        end
    endtask

    initial begin
        test_reset();
        test_dc_frame();
        test_impulse_gaps();
        test_stall();
        test_spurious_done();
        test_reset_mid_frame();
        test_frame_check();
        repeat (2) tick();
        checks++;
        if (err_cnt != m_err_exp) begin
            failures++;
            $display("FAIL err_pulse_total got=%0d expected=%0d", err_cnt, m_err_exp);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
